// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction over a
// ready handshake, holds it for one execute cycle and computes the next PC.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        InvZero,
    input  logic        Zero,
    input  logic [31:0] Da,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [XLEN-1:0] instr_q, instr_nxt;
    logic            valid_q, valid_nxt;
    logic            req_q, req_nxt;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] target;
    logic            take_branch;

    assign seq_pc      = pc_q + XLEN'(4);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = seq_pc;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign imem_req    = req_q;

    // Next-PC select: jr beats j beats a taken branch beats sequential.
    always_comb begin
        br_off      = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        take_branch = Branch & (Zero ^ InvZero);
        target      = seq_pc;
        if (JumpReg) begin
            target = Da & ~XLEN'(3);
        end else if (Jump) begin
            target = {seq_pc[31:28], instr_q[25:0], 2'b00};
        end else if (take_branch) begin
            target = seq_pc + br_off;
        end
    end

    // Fetch/execute sequencing and next register values.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        valid_nxt = valid_q;
        req_nxt   = req_q;
        case (state)
            S_REQ: begin
                if (imem_ready) begin
                    instr_nxt = imem_data;
                    valid_nxt = 1'b1;
                    req_nxt   = 1'b0;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    pc_nxt    = target;
                    valid_nxt = 1'b0;
                    req_nxt   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
            valid_q <= valid_nxt;
            req_q   <= req_nxt;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: fetch records are queued when
// a fetch is driven and compared when the DUT raises instr_valid.
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] word;
    } fetch_t;

    logic        clk;
    logic        reset;
    logic        w_reset;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        stall;
    logic        Branch, Jump, JumpReg, InvZero, Zero;
    logic [31:0] Da;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instruction, pc, pc_plus4;

    logic        w_imem_req, w_instr_valid;
    logic [31:0] w_imem_addr, w_instruction, w_pc, w_pc_plus4;

    int          checks = 0;
    int          errors = 0;
    fetch_t      exp_q[$];
    logic [31:0] model_pc;
    logic        valid_d = 1'b0;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data), .stall(stall),
        .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg), .InvZero(InvZero),
        .Zero(Zero), .Da(Da), .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(w_reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data), .stall(stall),
        .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg), .InvZero(InvZero),
        .Zero(Zero), .Da(Da), .instruction(w_instruction), .instr_valid(w_instr_valid),
        .pc(w_pc), .pc_plus4(w_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: each rising instr_valid must match the oldest queued fetch.
    always @(negedge clk) begin
        if (!reset && instr_valid && !valid_d) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: valid instruction %h at pc %h, none expected", instruction, pc);
            end else begin
                fetch_t f;
                f = exp_q.pop_front();
                if (pc !== f.addr || instruction !== f.word) begin
                    errors++;
                    $display("FAIL sb_fetch: got pc=%h instr=%h, expected pc=%h instr=%h",
                             pc, instruction, f.addr, f.word);
                end
            end
        end
        valid_d = instr_valid;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        Branch = 1'b0; Jump = 1'b0; JumpReg = 1'b0; InvZero = 1'b0; Zero = 1'b0; Da = '0;
    endtask

    task automatic push_fetch(input logic [31:0] addr, input logic [31:0] word);
        fetch_t f;
        f.addr = addr;
        f.word = word;
        exp_q.push_back(f);
    endtask

    // One zero-wait fetch followed by one unstalled execute cycle; returns new pc.
    task automatic run_instr(input logic [31:0] word, input logic br, input logic jmp,
                             input logic jr, input logic inv, input logic z,
                             input logic [31:0] da, output logic [31:0] npc);
        stall = 1'b0;
        imem_ready = 1'b1;
        imem_data = word;
        push_fetch(model_pc, word);
        step();
        imem_ready = 1'b0;
        imem_data = $urandom;
        Branch = br; Jump = jmp; JumpReg = jr; InvZero = inv; Zero = z; Da = da;
        step();
        npc = pc;
        clear_ctrl();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (pc !== 32'h0 || instruction !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: pc=%h instr=%h valid=%b req=%b, expected 0/0/0/1",
                     pc, instruction, instr_valid, imem_req);
        end
        checks++;
        if (imem_addr !== 32'h0 || pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL reset_addr: imem_addr=%h pc_plus4=%h, expected 0/4", imem_addr, pc_plus4);
        end
        reset = 1'b0;
        model_pc = 32'h0;
    endtask

    task automatic test_sequential();
        logic [31:0] ea [5];
        logic        ev [5];
        ea = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
        ev = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        imem_ready = 1'b1;
        imem_data = 32'h2402_0001;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            if (i == 0) push_fetch(32'h0, 32'h2402_0001);
            if (i == 2) push_fetch(32'h4, 32'h2402_0001);
            checks++;
            if (imem_addr !== ea[i] || instr_valid !== ev[i] || imem_req !== !ev[i]) begin
                errors++;
                $display("FAIL seq_cycle%0d: addr=%h valid=%b req=%b, expected addr=%h valid=%b req=%b",
                         i, imem_addr, instr_valid, imem_req, ea[i], ev[i], !ev[i]);
            end
            if (i <= 1) begin
                checks++;
                if (pc_plus4 !== 32'h4) begin
                    errors++;
                    $display("FAIL seq_pc_plus4: got %h expected 00000004", pc_plus4);
                end
            end
        end
        imem_ready = 1'b0;
        model_pc = 32'h8;
    endtask

    task automatic test_wait_states();
        imem_ready = 1'b0;
        imem_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0 ||
                instruction !== 32'h2402_0001) begin
                errors++;
                $display("FAIL wait_cycle%0d: req=%b addr=%h valid=%b instr=%h, expected 1/00000008/0/24020001",
                         i, imem_req, imem_addr, instr_valid, instruction);
            end
        end
        imem_ready = 1'b1;
        imem_data = 32'h1111_2222;
        push_fetch(32'h8, 32'h1111_2222);
        step();
        imem_ready = 1'b0;
        checks++;
        if (instruction !== 32'h1111_2222 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL wait_latch: instr=%h valid=%b req=%b, expected 11112222/1/0",
                     instruction, instr_valid, imem_req);
        end
        step();
        checks++;
        if (pc !== 32'hC) begin
            errors++;
            $display("FAIL wait_next_pc: got %h expected 0000000c", pc);
        end
        model_pc = 32'hC;
    endtask

    task automatic test_branch();
        logic [31:0] npc;
        run_instr(32'h0, 0, 0, 0, 0, 0, 32'h0, npc);
        checks++;
        if (npc !== 32'h10) begin errors++; $display("FAIL br_setup: got %h expected 00000010", npc); end
        model_pc = 32'h10;
        run_instr(32'h1022_FFFE, 1, 0, 0, 0, 1, 32'h0, npc);
        checks++;
        if (npc !== 32'hC) begin errors++; $display("FAIL beq_taken: got %h expected 0000000c", npc); end
        model_pc = 32'hC;
        run_instr(32'h0, 0, 0, 0, 0, 0, 32'h0, npc);
        model_pc = 32'h10;
        run_instr(32'h1422_FFFE, 1, 0, 0, 1, 1, 32'h0, npc);
        checks++;
        if (npc !== 32'h14) begin errors++; $display("FAIL bne_not_taken: got %h expected 00000014", npc); end
        model_pc = 32'h14;
        run_instr(32'h1422_FFFE, 1, 0, 0, 1, 0, 32'h0, npc);
        checks++;
        if (npc !== 32'h10) begin errors++; $display("FAIL bne_taken: got %h expected 00000010", npc); end
        model_pc = 32'h10;
    endtask

    task automatic test_jumps();
        logic [31:0] npc;
        run_instr(32'h1022_FFFE, 1, 0, 1, 0, 1, 32'h0040_0008, npc);
        checks++;
        if (npc !== 32'h0040_0008) begin errors++; $display("FAIL jr_over_branch: got %h expected 00400008", npc); end
        model_pc = 32'h0040_0008;
        run_instr(32'h0800_0100, 0, 1, 0, 0, 0, 32'h0, npc);
        checks++;
        if (npc !== 32'h0000_0400) begin errors++; $display("FAIL j_target: got %h expected 00000400", npc); end
        model_pc = 32'h0000_0400;
        run_instr(32'h0, 0, 0, 1, 0, 0, 32'h0040_000B, npc);
        checks++;
        if (npc !== 32'h0040_0008) begin errors++; $display("FAIL jr_misaligned: got %h expected 00400008", npc); end
        model_pc = 32'h0040_0008;
        run_instr(32'h0800_0100, 0, 1, 1, 0, 0, 32'h0000_0123, npc);
        checks++;
        if (npc !== 32'h0000_0120) begin errors++; $display("FAIL jr_and_j: got %h expected 00000120", npc); end
        model_pc = 32'h0000_0120;
    endtask

    task automatic test_stall_reset();
        stall = 1'b1;
        imem_ready = 1'b1;
        imem_data = 32'hCAFE_0042;
        push_fetch(32'h120, 32'hCAFE_0042);
        step();
        for (int i = 0; i < 5; i++) begin
            imem_data = $urandom;
            Branch = 1'b1; Jump = 1'b1; JumpReg = 1'b1; Zero = 1'b1; Da = $urandom;
            step();
            checks++;
            if (pc !== 32'h120 || instruction !== 32'hCAFE_0042 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: pc=%h instr=%h valid=%b req=%b, expected 00000120/cafe0042/1/0",
                         i, pc, instruction, instr_valid, imem_req);
            end
        end
        clear_ctrl();
        reset = 1'b1;
        step();
        checks++;
        if (pc !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b1 || instruction !== 32'h0) begin
            errors++;
            $display("FAIL stall_reset: pc=%h valid=%b req=%b instr=%h, expected 0/0/1/0",
                     pc, instr_valid, imem_req, instruction);
        end
        reset = 1'b0;
        stall = 1'b0;
        imem_ready = 1'b0;
        step();
        imem_ready = 1'b1;
        imem_data = 32'hBAD0_BAD0;
        reset = 1'b1;
        step();
        checks++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0 || imem_req !== 1'b1 || pc !== 32'h0) begin
            errors++;
            $display("FAIL req_reset: valid=%b instr=%h req=%b pc=%h, expected 0/0/1/0",
                     instr_valid, instruction, imem_req, pc);
        end
        imem_ready = 1'b0;
        model_pc = 32'h0;
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        w_reset = 1'b1;
        step();
        w_reset = 1'b0;
        checks++;
        if (w_imem_addr !== 32'hFFFF_FFFC || w_pc_plus4 !== 32'h0 || w_imem_req !== 1'b1) begin
            errors++;
            $display("FAIL wrap_reset: addr=%h pc_plus4=%h req=%b, expected fffffffc/0/1",
                     w_imem_addr, w_pc_plus4, w_imem_req);
        end
        imem_ready = 1'b1;
        imem_data = 32'h0;
        step();
        imem_ready = 1'b0;
        step();
        checks++;
        if (w_imem_addr !== 32'h0 || w_imem_req !== 1'b1) begin
            errors++;
            $display("FAIL wrap_next: addr=%h req=%b, expected 00000000/1", w_imem_addr, w_imem_req);
        end
    endtask

    initial begin
        reset = 1'b1;
        w_reset = 1'b1;
        imem_ready = 1'b0;
        imem_data = '0;
        stall = 1'b0;
        clear_ctrl();
        model_pc = '0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch();
        test_jumps();
        test_stall_reset();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d fetches never became valid, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
